add_sched: RTL and testbench

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched_pkg.sv | 44 ++++
 rtl/rr_arb2.sv | 30 +++
 rtl/add_sched.sv | 124 ++++++++++++
 tb/tb_add_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_sched_pkg.sv
// Shared encodings for the two-requester add/sub scheduler.
// Imported by the arbiter and the top.
package add_sched_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int OP_SUB  = 0;
    localparam int OP_WIDE = 1;

    localparam int F_ZF = 0;
    localparam int F_PF = 1;
    localparam int F_SF = 2;
    localparam int F_OF = 3;
    localparam int F_CF = 4;

    typedef struct packed {
        logic        id;
        logic        sub;
        logic        wide;
        logic [63:0] a;
        logic [63:0] b;
    } job_t;

    function automatic logic [4:0] mk_flags(
        input logic cf,
        input logic of,
        input logic sf,
        input logic pf,
        input logic zf
    );
        logic [4:0] f;
        f       = '0;
        f[F_CF] = cf;
        f[F_OF] = of;
        f[F_SF] = sf;
        f[F_PF] = pf;
        f[F_ZF] = zf;
        return f;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer names the favoured requester
// and moves to the other one whenever a grant is taken.
module rr_arb2
    import add_sched_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= PRIO_INIT;
        else if (|gnt)   ptr <= ~gnt[1];
    end

endmodule

// File: rtl/add_sched.sv
// Shares one 32-bit add/sub between two requesters; wide ops take
// a low pass then a high pass that consumes the stored carry.
module add_sched
    import add_sched_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [1:0]  r0_op,
    input  logic [63:0] r0_a,
    input  logic [63:0] r0_b,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [1:0]  r1_op,
    input  logic [63:0] r1_a,
    input  logic [63:0] r1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_s,
    output logic [4:0]  rsp_flags
);

    logic [1:0]  state;
    job_t        job;
    logic        carry;
    logic [31:0] lo;
    logic [1:0]  gnt;
    logic        accept;

    rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({r1_valid, r0_valid}),
        .en    (state == S_IDLE),
        .gnt   (gnt)
    );

    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];
    assign accept   = |gnt;

    logic        hi_pass;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [32:0] sum;
    logic        cout;
    logic        c31;
    logic [63:0] res;
    logic [4:0]  flags;

    // single adder: operand halves and carry-in selected by pass
    always_comb begin
        hi_pass = (state == S_HI);
        x       = hi_pass ? job.a[63:32] : job.a[31:0];
        y       = hi_pass ? job.b[63:32] : job.b[31:0];
        y       = y ^ {32{job.sub}};
        cin     = hi_pass ? carry : job.sub;
        sum     = {1'b0, x} + {1'b0, y} + {32'd0, cin};
        cout    = sum[32];
        c31     = x[31] ^ y[31] ^ sum[31];
        res     = hi_pass ? {sum[31:0], lo} : {32'd0, sum[31:0]};
        flags   = mk_flags(cout ^ job.sub, c31 ^ cout, sum[31],
                           ~^res[7:0], ~|res);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            job       <= '0;
            carry     <= 1'b0;
            lo        <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_s     <= '0;
            rsp_flags <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        job.id   <= gnt[1];
                        job.sub  <= gnt[1] ? r1_op[OP_SUB]  : r0_op[OP_SUB];
                        job.wide <= gnt[1] ? r1_op[OP_WIDE] : r0_op[OP_WIDE];
                        job.a    <= gnt[1] ? r1_a : r0_a;
                        job.b    <= gnt[1] ? r1_b : r0_b;
                        state    <= S_LO;
                    end
                end
                S_LO: begin
                    lo    <= sum[31:0];
                    carry <= cout;
                    if (job.wide) begin
                        state <= S_HI;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= job.id;
                        rsp_s     <= res;
                        rsp_flags <= flags;
                        state     <= S_RESP;
                    end
                end
                S_HI: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= job.id;
                    rsp_s     <= res;
                    rsp_flags <= flags;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched: flags, latency, round-robin,
// response backpressure and mid-operation reset.
module tb_add_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [1:0]  r0_op, r1_op;
    logic [63:0] r0_a, r0_b, r1_a, r1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_s;
    logic [4:0]  rsp_flags;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    add_sched #(.PRIO_INIT(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_op     (r0_op),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_op     (r1_op),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_flags (rsp_flags)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // present one op, confirm grant, then drop valid after the accept edge
    task automatic send(input bit id, input logic [1:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input string tag);
        @(posedge clk);
        #1;
        if (id) begin
            r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
        end else begin
            r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
        end
        @(negedge clk);
        chk({tag, "_rdy"}, {63'd0, id ? r1_ready : r0_ready}, 64'd1);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int lat, input string tag);
        int cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt++;
            if (rsp_valid) break;
        end
        chk({tag, "_lat"}, 64'(cnt), 64'(lat));
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input bit id, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input int lat, input logic [63:0] es,
                          input logic [4:0] ef, input string tag);
        send(id, op, a, b, tag);
        wait_rsp(lat, tag);
        chk({tag, "_id"}, {63'd0, rsp_id}, {63'd0, id});
        chk({tag, "_s"}, rsp_s, es);
        chk({tag, "_flags"}, {59'd0, rsp_flags}, {59'd0, ef});
        take();
    endtask

    initial begin
        bit          g[$];
        bit          rid[$];
        logic [63:0] rs[$];
        logic [63:0] s0;
        logic [4:0]  f0;
        bit          seen;

        rst_n = 1'b0;
        r0_valid = 0; r1_valid = 0; rsp_ready = 0;
        r0_op = 0; r1_op = 0;
        r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
        do_reset();

        @(negedge clk);
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_id", {63'd0, rsp_id}, 64'd0);
        chk("rst_s", rsp_s, 64'd0);
        chk("rst_flags", {59'd0, rsp_flags}, 64'd0);
        chk("rst_rdy", {62'd0, r1_ready, r0_ready}, 64'd0);

        // {CF,OF,SF,PF,ZF}
        run_op(0, 2'b00, 64'hDEADBEEF_FFFFFFFF, 64'h1, 2,
               64'h0, 5'b10011, "add_wrap");
        run_op(1, 2'b01, 64'h80000000, 64'h1, 2,
               64'h7FFFFFFF, 5'b01010, "sub_ovf");
        run_op(0, 2'b10, 64'h00000000_FFFFFFFF, 64'h1, 3,
               64'h00000001_00000000, 5'b00010, "wide_add");
        run_op(1, 2'b11, 64'h0, 64'h1, 3,
               64'hFFFFFFFF_FFFFFFFF, 5'b10110, "wide_sub");
        run_op(0, 2'b00, 64'h7FFFFFFF, 64'h1, 2,
               64'h80000000, 5'b01110, "add_sovf");
        run_op(1, 2'b00, 64'h3, 64'h4, 2,
               64'h7, 5'b00000, "add_odd");

        // alternation from a fresh reset
        do_reset();
        rsp_ready = 1'b1;
        r0_valid = 1; r0_op = 2'b00; r0_a = 64'd1;  r0_b = 64'd1;
        r1_valid = 1; r1_op = 2'b01; r1_a = 64'd10; r1_b = 64'd5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r0_ready && r1_ready) chk("rr_both", 64'd1, 64'd0);
            if (r0_ready) g.push_back(1'b0);
            if (r1_ready) g.push_back(1'b1);
            if (rsp_valid) begin
                rid.push_back(rsp_id);
                rs.push_back(rsp_s);
            end
        end
        @(posedge clk);
        #1;
        r0_valid = 0; r1_valid = 0; rsp_ready = 0;
        chk("rr_ngnt", 64'(g.size()), 64'd4);
        chk("rr_nrsp", 64'(rid.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < g.size())
                chk($sformatf("rr_gnt%0d", i), {63'd0, g[i]}, 64'(i % 2));
            if (i < rid.size()) begin
                chk($sformatf("rr_id%0d", i), {63'd0, rid[i]}, 64'(i % 2));
                chk($sformatf("rr_s%0d", i), rs[i], (i % 2) ? 64'd5 : 64'd2);
            end
        end

        // backpressure: hold response 5 cycles while r1 keeps asking
        send(0, 2'b00, 64'h1234, 64'h1111, "bp");
        wait_rsp(2, "bp");
        s0 = rsp_s;
        f0 = rsp_flags;
        chk("bp_s", s0, 64'h2345);
        @(posedge clk);
        #1;
        r1_valid = 1; r1_op = 2'b00; r1_a = 64'd1; r1_b = 64'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_v%0d", i), {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("bp_s%0d", i), rsp_s, s0);
            chk($sformatf("bp_f%0d", i), {59'd0, rsp_flags}, {59'd0, f0});
            chk($sformatf("bp_rdy%0d", i), {62'd0, r1_ready, r0_ready},
                64'd0);
        end
        r1_valid = 0;
        take();
        @(negedge clk);
        chk("bp_done", {63'd0, rsp_valid}, 64'd0);

        // reset during the high pass of a wide op
        send(1, 2'b10, 64'h5_00000000, 64'h6_00000000, "mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_v", {63'd0, rsp_valid}, 64'd0);
        chk("mid_s", rsp_s, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mid_norsp", {63'd0, seen}, 64'd0);
        run_op(1, 2'b10, 64'h5_00000000, 64'h6_00000000, 3,
               64'hB_00000000, 5'b00010, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
